// File: rtl/tick_pkg.sv
// Shared types and constants for the tick-driven BCD counter.
package tick_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk domain and flags its rising edges.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // Combinational so the consumer can register the pulse and count it in the same edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/tick_bcd_counter.sv
// Counts rising edges of a slow divided clock in a multi-digit BCD counter
// under start/stop/clear control; also emits per-edge tick and rollover wrap pulses.
module tick_bcd_counter
    import tick_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      slow_clk,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      running,
    output logic                      tick,
    output logic                      wrap,
    output state_e                    state_dbg
);

    localparam int BW = BCD_W * DIGITS;

    logic            rise;
    state_e          state_q, state_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   bcd_inc;
    logic [DIGITS-1:0] nine;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic            running_q, running_d;
    logic            count_en;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (slow_clk),
        .rise     (rise)
    );

    // bcd_inc is the count plus one; a digit steps only when every lower digit is 9.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign nine[k] = (bcd_q[k*BCD_W +: BCD_W] == BCD_MAX);
        if (k == 0) begin : g_lsd
            assign bcd_inc[BCD_W-1:0] = nine[0] ? '0 : bcd_q[BCD_W-1:0] + 4'd1;
        end else begin : g_upper
            assign bcd_inc[k*BCD_W +: BCD_W] =
                (&nine[k-1:0]) ? (nine[k] ? '0 : bcd_q[k*BCD_W +: BCD_W] + 4'd1)
                               : bcd_q[k*BCD_W +: BCD_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        wrap_d   = 1'b0;
        tick_d   = rise;
        count_en = (state_q == RUN) && rise;
        if (clear) begin
            state_d = IDLE;
            bcd_d   = '0;
        end else begin
            case (state_q)
                IDLE, PAUSE: if (start) state_d = RUN;
                RUN:         if (stop)  state_d = PAUSE;
                default:     state_d = IDLE;
            endcase
            if (count_en) begin
                bcd_d  = bcd_inc;
                wrap_d = &nine;
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
        end
    end

    assign bcd       = bcd_q;
    assign running   = running_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: control-table vectors, directed edge-aligned sequences
// and random traffic, all checked every cycle against an integer-count reference model.
module tb_tick_bcd_counter;
    import tick_pkg::*;

    localparam int DIGITS = 2;
    localparam int S      = 2;
    localparam int BW     = 4 * DIGITS;
    localparam int MAXC   = 10 ** DIGITS - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          slow_clk = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clear = 1'b0;
    logic [BW-1:0] bcd;
    logic          running;
    logic          tick;
    logic          wrap;
    state_e        state_dbg;

    tick_bcd_counter #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .slow_clk  (slow_clk),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .bcd       (bcd),
        .running   (running),
        .tick      (tick),
        .wrap      (wrap),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Count kept as a plain integer; the synchronizer is a delay line of slow_clk samples.
    state_e m_state = IDLE;
    int     m_count = 0;
    bit     m_tick  = 1'b0;
    bit     m_wrap  = 1'b0;
    bit     m_run   = 1'b0;
    bit     m_hist[$];

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset_hist();
        m_hist.delete();
        for (int i = 0; i <= S; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_step();
        bit e;
        if (!rst_n) begin
            m_state = IDLE;
            m_count = 0;
            m_tick  = 1'b0;
            m_wrap  = 1'b0;
            m_run   = 1'b0;
            model_reset_hist();
        end else begin
            // m_hist[0] is the newest sample; an edge is a 0->1 step at depth S.
            e      = m_hist[S-1] && !m_hist[S];
            m_tick = e;
            m_wrap = 1'b0;
            if (clear) begin
                m_count = 0;
            end else if (m_state == RUN && e) begin
                if (m_count == MAXC) begin
                    m_count = 0;
                    m_wrap  = 1'b1;
                end else begin
                    m_count = m_count + 1;
                end
            end
            if (clear)                         m_state = IDLE;
            else if (m_state != RUN && start)  m_state = RUN;
            else if (m_state == RUN && stop)   m_state = PAUSE;
            m_run = (m_state == RUN);
            m_hist.push_front(slow_clk);
            void'(m_hist.pop_back());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("bcd", 32'(bcd), 32'(to_bcd(m_count)));
        check("tick", 32'(tick), 32'(m_tick));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("running", 32'(running), 32'(m_run));
        check("state", 32'(state_dbg), 32'(m_state));
        if (tick === 1'b1) tick_cnt++;
        if (wrap === 1'b1) wrap_cnt++;
    endtask

    task automatic cmd(input logic st, input logic sp, input logic cl);
        start = st; stop = sp; clear = cl;
        cycle();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    logic [BW-1:0] snap_bcd;
    logic          snap_run, snap_tick, snap_wrap;
    state_e        snap_state;

    // One slow_clk period (ph high, ph low). Commands are applied only in cycle
    // cmd_at; cmd_at == S is the cycle in which the internal edge is seen.
    task automatic slow_pulse(input int ph, input int cmd_at,
                              input logic st, input logic sp, input logic cl);
        slow_clk = 1'b1;
        for (int i = 0; i < 2 * ph; i++) begin
            if (i == ph) slow_clk = 1'b0;
            start = (i == cmd_at) ? st : 1'b0;
            stop  = (i == cmd_at) ? sp : 1'b0;
            clear = (i == cmd_at) ? cl : 1'b0;
            cycle();
            if (i == cmd_at) begin
                snap_bcd = bcd; snap_run = running; snap_tick = tick;
                snap_wrap = wrap; snap_state = state_dbg;
            end
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic pulses(input int n, input int ph);
        for (int i = 0; i < n; i++) slow_pulse(ph, -1, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- control table ----------------
    typedef struct {
        logic   rst_n;
        logic   start;
        logic   stop;
        logic   clear;
        state_e exp_state;
        logic   exp_running;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int ph_left;
        model_reset_hist();

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, IDLE,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, IDLE,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, RUN,   1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, RUN,   1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, PAUSE, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, PAUSE, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, RUN,   1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, IDLE,  1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, IDLE,  1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, RUN,   1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, IDLE,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, IDLE,  1'b0};

        // reset state
        rst_n = 1'b0;
        cycle();
        cycle();
        check("reset_bcd", 32'(bcd), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        cycle();

        // FSM control table, slow_clk held low
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; start = vecs[i].start;
            stop = vecs[i].stop; clear = vecs[i].clear;
            cycle();
            check($sformatf("vec%0d_state", i), 32'(state_dbg), 32'(vecs[i].exp_state));
            check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_running));
        end
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;

        // 10 periods of 64 cycles
        cmd(1'b1, 1'b0, 1'b0);
        tick_cnt = 0;
        pulses(10, 32);
        check("ten_ticks", 32'(tick_cnt), 32'd10);
        check("ten_bcd", 32'(bcd), 32'h10);
        check("ten_running", 32'(running), 32'h1);

        // wrap from 99 to 00
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        wrap_cnt = 0;
        pulses(99, 4);
        check("at_99", 32'(bcd), 32'h99);
        check("no_early_wrap", 32'(wrap_cnt), 32'd0);
        tick_cnt = 0;
        slow_pulse(32, S, 1'b0, 1'b0, 1'b0);
        check("wrap_bcd", 32'(snap_bcd), 32'h00);
        check("wrap_pulse", 32'(snap_wrap), 32'h1);
        check("wrap_with_tick", 32'(snap_tick), 32'h1);
        check("wrap_once", 32'(wrap_cnt), 32'd1);
        check("wrap_ticks", 32'(tick_cnt), 32'd1);

        // pause holds the count, ticks continue
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        pulses(5, 4);
        check("pre_pause", 32'(bcd), 32'h05);
        cmd(1'b0, 1'b1, 1'b0);
        tick_cnt = 0;
        pulses(3, 32);
        check("pause_hold", 32'(bcd), 32'h05);
        check("pause_ticks", 32'(tick_cnt), 32'd3);
        check("pause_state", 32'(state_dbg), 32'(PAUSE));
        cmd(1'b1, 1'b0, 1'b0);
        pulses(1, 32);
        check("resume", 32'(bcd), 32'h06);

        // clear coincident with an edge at 42
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        pulses(42, 4);
        check("at_42", 32'(bcd), 32'h42);
        slow_pulse(32, S, 1'b0, 1'b0, 1'b1);
        check("clear_edge_bcd", 32'(snap_bcd), 32'h00);
        check("clear_edge_state", 32'(snap_state), 32'(IDLE));
        check("clear_edge_running", 32'(snap_run), 32'h0);
        check("clear_edge_wrap", 32'(snap_wrap), 32'h0);

        // start coincident with an edge, then stop coincident with an edge
        slow_pulse(32, S, 1'b1, 1'b0, 1'b0);
        check("start_edge_bcd", 32'(snap_bcd), 32'h00);
        check("start_edge_running", 32'(snap_run), 32'h1);
        pulses(1, 32);
        check("after_start_edge", 32'(bcd), 32'h01);
        slow_pulse(32, S, 1'b0, 1'b1, 1'b0);
        check("stop_edge_bcd", 32'(snap_bcd), 32'h02);
        check("stop_edge_state", 32'(snap_state), 32'(PAUSE));

        // reset one cycle after slow_clk rises, at 37
        cmd(1'b0, 1'b0, 1'b1);
        cmd(1'b1, 1'b0, 1'b0);
        pulses(37, 4);
        check("at_37", 32'(bcd), 32'h37);
        tick_cnt = 0;
        wrap_cnt = 0;
        slow_clk = 1'b1;
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        repeat (30) cycle();
        slow_clk = 1'b0;
        repeat (32) cycle();
        // the only tick is the one from the chain refilling after reset
        check("rst_refill_ticks", 32'(tick_cnt), 32'd1);
        check("rst_wraps", 32'(wrap_cnt), 32'd0);
        check("rst_after_bcd", 32'(bcd), 32'h0);

        // random traffic against the model
        ph_left = $urandom_range(S + 1, 12);
        for (int c = 0; c < 4000; c++) begin
            if (ph_left == 0) begin
                slow_clk = ~slow_clk;
                ph_left  = $urandom_range(S + 1, 12);
            end
            ph_left--;
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            clear = ($urandom_range(0, 499) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
            cycle();
        end
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Downstream consumer of the divide-by-64 clock output.
- Samples the slow divided clock as data in the fast `clk` domain and converts each rising edge into a one-cycle `tick`.
- Counts ticks in a DIGITS-wide BCD counter under start/stop/clear control.
- Feeds display and timekeeping logic with a parallel BCD value, a run status and a wrap pulse.

Parameters:
- DIGITS, 2, number of BCD digits; count range is 0 to 10^DIGITS-1.
- SYNC_STAGES, 2, flip-flops in the `slow_clk` synchronizer chain; minimum 2.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  reset, synchronous, active-low.
- slow_clk  input  1  divided clock from the frequency divider; treated as an asynchronous data input.
- start  input  1  level-sampled command: begin or resume counting.
- stop  input  1  level-sampled command: pause counting.
- clear  input  1  level-sampled command: zero the count and return to IDLE.
- bcd  output  4*DIGITS  count value; digit 0 in bits [3:0].
- running  output  1  high while the FSM is in RUN.
- tick  output  1  one-cycle pulse per detected `slow_clk` rising edge.
- wrap  output  1  one-cycle pulse when the count rolls over from all-9s to all-0s.

Behaviour:
- Reset, applied at a `clk` posedge while `rst_n`=0:
  - synchronizer flops and edge-history flop cleared to 0;
  - `bcd`=0, `tick`=0, `wrap`=0, `running`=0;
  - state=IDLE.
- Edge detection:
  - `edge` = last sync stage & ~history flop.
  - `tick` is registered from `edge`.
  - Latency from the first `clk` edge that samples `slow_clk` high to `tick` high is SYNC_STAGES+1 cycles.
  - `tick` fires regardless of FSM state.
- `slow_clk` timing requirement: high and low phases each at least SYNC_STAGES+1 `clk` cycles. The divider provides 32 cycles per phase.
- FSM states: IDLE, RUN, PAUSE.
  - `clear`=1 in any state: go to IDLE and set `bcd`=0. `clear` has highest priority.
  - IDLE or PAUSE with `start`=1: go to RUN. `stop` is ignored in these states.
  - RUN with `stop`=1: go to PAUSE. `start` is ignored in RUN, so `start`+`stop` together in RUN gives PAUSE.
  - Otherwise the state holds.
  - `running` is a registered decode of state==RUN and is high in the cycle after the transition.
- Counting:
  - When the current state is RUN and `edge`=1, `bcd` increments at the next `clk` edge, in the same cycle `tick` rises.
  - An edge in the cycle `stop` is sampled is counted, because the state is still RUN.
  - An edge in the cycle `start` is sampled is not counted.
  - `edge` together with `clear` yields `bcd`=0; `clear` wins.
- BCD arithmetic:
  - Each digit counts 0 to 9.
  - Digit k increments only when all lower digits equal 9.
  - All-9s plus 1 gives all-0s with `wrap`=1 for exactly one cycle, aligned with `tick`.
- `bcd` holds its value in PAUSE. It is only zeroed by `clear` or reset.
- Reset mid-operation: reset overrides everything in the same cycle. No `tick` or `wrap` is emitted for an edge already in the synchronizer.
- After reset deassertion, if `slow_clk` is already high, one `tick` fires once the chain fills. This is required behaviour; it is not counted because the state is IDLE.

Decomposition:
- Package `tick_pkg` holds:
  - state enum {IDLE, RUN, PAUSE};
  - BCD_MAX constant = 4'd9;
  - BCD_W constant = 4.
- Sub-module `sync_edge_detect` (parameter SYNC_STAGES; ports `clk`, `rst_n`, `async_in`, `rise`) contains the synchronizer chain and history flop.
- The top level instantiates `sync_edge_detect` once and contains the FSM and the generate-loop BCD chain.

Test Plan:
- Reset then `start`, then drive `slow_clk` with period 64 `clk` for 10 periods -> `tick` pulses 10 times, each one cycle wide; `bcd`=8'h10; `running`=1.
- Run 99 edges, then 1 more -> `bcd` goes 8'h99 to 8'h00; `wrap` is high for exactly that one cycle, coincident with `tick`.
- Count to 8'h05, assert `stop`, apply 3 edges, then assert `start` -> `bcd` holds 8'h05 through PAUSE; `tick` still pulses 3 times; counting resumes at 8'h06.
- Assert `clear` in the same cycle the internal `edge` fires at `bcd`=8'h42 -> `bcd`=8'h00, state=IDLE, `running`=0, `wrap`=0.
- Assert `start` in the exact cycle `edge`=1 from IDLE -> that edge is not counted (`bcd`=8'h00), and the next edge gives 8'h01. Then assert `stop` coincident with an edge -> that edge is counted.
- Drop `rst_n` for 1 cycle mid-run at `bcd`=8'h37, one cycle after `slow_clk` rises -> all outputs are 0 on the next cycle; no `tick` or `wrap` is produced for that edge; state=IDLE.
